// File: rtl/geofence_poly_if.sv
// Frame input and result bus for the point-in-convex-polygon engine.
interface geofence_poly_if #(
  parameter int CW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] X;
  logic [CW-1:0] Y;
  logic          reuse;
  logic          valid;
  logic          is_inside;
  logic          on_edge;

  modport slave (
    input  in_valid, X, Y, reuse,
    output in_ready, valid, is_inside, on_edge
  );

  modport master (
    output in_valid, X, Y, reuse,
    input  in_ready, valid, is_inside, on_edge
  );
endinterface

// File: rtl/geofence_poly.sv
// Point-in-convex-polygon engine: reads target + NV vertices, sorts CCW about v0,
// then tests the target against each edge and reports inside / on-edge.
module geofence_poly #(
  parameter int CW = 10,
  parameter int NV = 6
) (
  input  logic clk,
  input  logic reset,
  geofence_poly_if.slave bus
);
  localparam int DW = CW + 1;
  localparam int PW = 2 * CW + 2;
  localparam int XW = 2 * CW + 3;
  localparam int IW = $clog2(NV);
  localparam int KW = $clog2(NV + 1);

  typedef enum logic [2:0] {IDLE, READ, SORT, CAL, OUT} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic            loaded_q, loaded_d;
  logic [CW-1:0]   tx_q, tx_d, ty_q, ty_d;
  logic [CW-1:0]   vx_q [NV];
  logic [CW-1:0]   vx_d [NV];
  logic [CW-1:0]   vy_q [NV];
  logic [CW-1:0]   vy_d [NV];
  logic [NV-1:0]   pos_q, pos_d, zero_q, zero_d;
  logic            inside_q, inside_d, edge_q, edge_d;
  logic [IW-1:0]   k_idx, n_idx;
  logic signed [XW-1:0] cr_sort, c_cal;

  // (b-a) x (c-a) at full precision: DW-bit differences, PW-bit products, XW-bit result.
  function automatic logic signed [XW-1:0] cross3(
    input logic [CW-1:0] ax, ay, bx, by, cx, cy
  );
    logic signed [DW-1:0] ux, uy, wx, wy;
    logic signed [PW-1:0] p, q;
    ux = $signed({1'b0, bx}) - $signed({1'b0, ax});
    uy = $signed({1'b0, by}) - $signed({1'b0, ay});
    wx = $signed({1'b0, cx}) - $signed({1'b0, ax});
    wy = $signed({1'b0, cy}) - $signed({1'b0, ay});
    p  = PW'(ux) * PW'(wy);
    q  = PW'(uy) * PW'(wx);
    return XW'(p) - XW'(q);
  endfunction

  assign k_idx = (cnt_q < KW'(NV)) ? IW'(cnt_q) : '0;
  assign n_idx = (cnt_q >= KW'(NV - 1)) ? '0 : IW'(cnt_q + 1'b1);

  assign cr_sort = cross3(vx_q[0], vy_q[0], vx_q[i_q], vy_q[i_q], vx_q[j_q], vy_q[j_q]);
  assign c_cal   = cross3(vx_q[k_idx], vy_q[k_idx], vx_q[n_idx], vy_q[n_idx], tx_q, ty_q);

  assign bus.in_ready  = (state_q == READ);
  assign bus.valid     = (state_q == OUT);
  assign bus.is_inside = inside_q;
  assign bus.on_edge   = edge_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    i_d      = i_q;
    j_d      = j_q;
    loaded_d = loaded_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    pos_d    = pos_q;
    zero_d   = zero_q;
    inside_d = inside_q;
    edge_d   = edge_q;
    case (state_q)
      IDLE: begin
        state_d = READ;
        cnt_d   = '0;
      end
      READ: begin
        if (bus.in_valid) begin
          if (cnt_q == '0) begin
            tx_d = bus.X;
            ty_d = bus.Y;
            if (bus.reuse && loaded_q) begin
              state_d = CAL;
              cnt_d   = '0;
            end else begin
              cnt_d = KW'(1);
            end
          end else begin
            vx_d[IW'(cnt_q - 1'b1)] = bus.X;
            vy_d[IW'(cnt_q - 1'b1)] = bus.Y;
            if (cnt_q == KW'(NV)) begin
              state_d = SORT;
              cnt_d   = '0;
              i_d     = IW'(1);
              j_d     = IW'(2);
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      SORT: begin
        if (cr_sort[XW-1]) begin
          vx_d[i_q] = vx_q[j_q];
          vy_d[i_q] = vy_q[j_q];
          vx_d[j_q] = vx_q[i_q];
          vy_d[j_q] = vy_q[i_q];
        end
        if (j_q == IW'(NV - 1)) begin
          if (i_q == IW'(NV - 2)) begin
            state_d  = CAL;
            cnt_d    = '0;
            loaded_d = 1'b1;
          end else begin
            i_d = i_q + 1'b1;
            j_d = i_q + IW'(2);
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      CAL: begin
        // NV edge cycles, then one extra cycle reduces the registered per-edge flags.
        if (cnt_q < KW'(NV)) begin
          pos_d[k_idx]  = ~c_cal[XW-1] && (c_cal != '0);
          zero_d[k_idx] = (c_cal == '0);
          cnt_d         = cnt_q + 1'b1;
        end else begin
          inside_d = &pos_q;
          edge_d   = (&(pos_q | zero_q)) & (|zero_q);
          state_d  = OUT;
        end
      end
      OUT: begin
        state_d = READ;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      loaded_q <= 1'b0;
      tx_q     <= '0;
      ty_q     <= '0;
      pos_q    <= '0;
      zero_q   <= '0;
      inside_q <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      i_q      <= i_d;
      j_q      <= j_d;
      loaded_q <= loaded_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      pos_q    <= pos_d;
      zero_q   <= zero_d;
      inside_q <= inside_d;
      edge_q   <= edge_d;
    end
  end

  always_ff @(posedge clk) begin
    vx_q <= vx_d;
    vy_q <= vy_d;
  end
endmodule

// File: tb/tb_geofence_poly.sv
// Directed bench for geofence_poly: NV=6 and NV=3 instances, hand-computed geometry.
module tb_geofence_poly;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       v6, v3;
  logic [9:0] xin, yin;
  logic       rin;
  int         n_checks = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  geofence_poly_if #(.CW(10)) b6 ();
  geofence_poly_if #(.CW(10)) b3 ();

  assign b6.in_valid = v6;
  assign b6.X        = xin;
  assign b6.Y        = yin;
  assign b6.reuse    = rin;
  assign b3.in_valid = v3;
  assign b3.X        = xin;
  assign b3.Y        = yin;
  assign b3.reuse    = rin;

  geofence_poly #(.CW(10), .NV(6)) dut6 (.clk(clk), .reset(rst_n), .bus(b6));
  geofence_poly #(.CW(10), .NV(3)) dut3 (.clk(clk), .reset(rst_n), .bus(b3));

  // Hexagon A (shuffled) and hexagon B (shuffled)
  int ax [6] = '{600, 200, 400, 400, 600, 200};
  int ay [6] = '{500, 300, 600, 200, 300, 500};
  int bx [6] = '{800, 200, 1000, 0, 200, 800};
  int by [6] = '{1000, 0, 500, 500, 1000, 0};

  function automatic logic rdy(input bit s);
    return s ? b3.in_ready : b6.in_ready;
  endfunction
  function automatic logic vld(input bit s);
    return s ? b3.valid : b6.valid;
  endfunction
  function automatic logic ins(input bit s);
    return s ? b3.is_inside : b6.is_inside;
  endfunction
  function automatic logic edg(input bit s);
    return s ? b3.on_edge : b6.on_edge;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic beat(input bit s, input int x, input int y, input bit r);
    int t;
    t   = 0;
    xin = x[9:0];
    yin = y[9:0];
    rin = r;
    if (s) v3 = 1'b1; else v6 = 1'b1;
    @(negedge clk);
    while (!rdy(s) && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!rdy(s)) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    v3 = 1'b0;
    v6 = 1'b0;
  endtask

  task automatic result(input bit s, input string tag, input int lat, input bit ei, input bit ee);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      seen = vld(s);
    end
    check({tag, "_valid"}, int'(seen), 1);
    check({tag, "_lat"}, n, lat);
    check({tag, "_inside"}, int'(ins(s)), int'(ei));
    check({tag, "_edge"}, int'(edg(s)), int'(ee));
    @(posedge clk);
    #1;
    check({tag, "_strobe"}, int'(vld(s)), 0);
    check({tag, "_hold"}, int'(ins(s)), int'(ei));
  endtask

  task automatic full6(input int tx, input int ty, input int vx [6], input int vy [6], input bit stall);
    beat(1'b0, tx, ty, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (stall && i == 3) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_ready", int'(b6.in_ready), 1);
        end
        @(posedge clk);
        #1;
      end
      beat(1'b0, vx[i], vy[i], 1'b0);
    end
  endtask

  initial begin
    bit saw;
    rst_n = 1'b0;
    v6    = 1'b0;
    v3    = 1'b0;
    xin   = '0;
    yin   = '0;
    rin   = 1'b0;
    #12;
    check("rst_ready", int'(b6.in_ready), 0);
    check("rst_valid", int'(b6.valid), 0);
    check("rst_inside", int'(b6.is_inside), 0);
    check("rst_edge", int'(b6.on_edge), 0);
    check("rst_ready3", int'(b3.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    full6(400, 400, ax, ay, 1'b0);
    result(1'b0, "s1", 17, 1'b1, 1'b0);
    beat(1'b0, 300, 400, 1'b1);
    result(1'b0, "s4_reuse", 7, 1'b1, 1'b0);
    full6(600, 400, ax, ay, 1'b0);
    result(1'b0, "s2_edge", 17, 1'b0, 1'b1);
    beat(1'b0, 400, 200, 1'b1);
    result(1'b0, "s2_vertex", 7, 1'b0, 1'b1);
    beat(1'b0, 700, 400, 1'b1);
    result(1'b0, "s3_out", 7, 1'b0, 1'b0);
    beat(1'b0, 0, 0, 1'b1);
    result(1'b0, "s3_origin", 7, 1'b0, 1'b0);

    full6(100, 500, bx, by, 1'b0);
    result(1'b0, "s4_newfence", 17, 1'b1, 1'b0);
    beat(1'b0, 900, 200, 1'b1);
    result(1'b0, "s4_newout", 7, 1'b0, 1'b0);
    beat(1'b0, 500, 0, 1'b1);
    result(1'b0, "s4_newedge", 7, 1'b0, 1'b1);

    full6(400, 400, ax, ay, 1'b1);
    result(1'b0, "s5_stall", 17, 1'b1, 1'b0);

    full6(300, 400, ax, ay, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("s6_rst_valid", int'(b6.valid), 0);
    check("s6_rst_inside", int'(b6.is_inside), 0);
    check("s6_rst_ready", int'(b6.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b0, 400, 400, 1'b1);
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (b6.valid) saw = 1'b1;
    end
    check("s6_no_early_valid", int'(saw), 0);
    check("s6_wait_ready", int'(b6.in_ready), 1);
    for (int i = 0; i < 6; i++) beat(1'b0, ax[i], ay[i], 1'b0);
    result(1'b0, "s6_full", 17, 1'b1, 1'b0);

    beat(1'b1, 100, 100, 1'b0);
    beat(1'b1, 0, 0, 1'b0);
    beat(1'b1, 0, 1023, 1'b0);
    beat(1'b1, 1023, 0, 1'b0);
    result(1'b1, "tri_in", 5, 1'b1, 1'b0);
    beat(1'b1, 600, 600, 1'b1);
    result(1'b1, "tri_out", 4, 1'b0, 1'b0);
    beat(1'b1, 0, 500, 1'b1);
    result(1'b1, "tri_edge", 4, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
